dram_result_streamer: RTL and testbench

//  Downstream stage of downsampling_CPU: once processing finishes, reads the result region out of DRAM
//  (byte-wide, 16-bit address) and presents it as a valid/ready byte stream to the output sink (UART tx / file writer).

---
 rtl/ds_pkg.sv | 17 +
 rtl/stream_fifo.sv | 69 ++++++
 rtl/dram_result_streamer.sv | 137 +++++++++++++
 tb/tb_dram_result_streamer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// Shared definitions for the downsampling_CPU output path: default bus widths,
// result-region size and the result streamer FSM encoding.
package ds_pkg;

    localparam int DS_ADDR_W = 16;
    localparam int DS_DATA_W = 8;

    // 2x2 downsampling of the input image leaves a quarter of the bytes.
    localparam int IMAGE_BYTES  = 90000;
    localparam int RESULT_BYTES = IMAGE_BYTES / 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO; head valid the cycle after push.
// Push into a full FIFO or pop of an empty one is dropped; callers hold credits.
module stream_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_vld_i && !full_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end

endmodule

// File: rtl/dram_result_streamer.sv
// Reads a DRAM result region and streams it out as valid/ready bytes.
// First byte RD_LATENCY+1 cycles after busy rises; reads stall when FIFO credits run out.
module dram_result_streamer
    import ds_pkg::*;
#(
    parameter int ADDR_W     = DS_ADDR_W,
    parameter int DATA_W     = DS_DATA_W,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    logic [1:0]            state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [LEN_W-1:0]      length_q, length_d;
    logic [LEN_W-1:0]      issued_q, issued_d;
    logic [LEN_W-1:0]      accepted_q, accepted_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;

    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  issue;
    logic [OCC_W-1:0]      inflight;
    logic [OCC_W-1:0]      occupancy;

    assign pop = !fifo_empty && out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + OCC_W'(pipe_q[i]);
        end
    end

    // Every outstanding read already owns a FIFO slot, so a push can never find the FIFO full.
    assign occupancy = OCC_W'(fifo_count) + inflight - OCC_W'(pop);
    assign issue     = (state_q == ST_ISSUE) && !(fifo_full && !pop)
                       && (occupancy < OCC_W'(FIFO_DEPTH));

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        length_d   = length_q;
        issued_d   = issued_q + LEN_W'(issue);
        accepted_d = accepted_q + LEN_W'(pop);
        pipe_d     = '0;
        pipe_d[0]  = issue;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    length_d   = length;
                    issued_d   = '0;
                    accepted_d = '0;
                    state_d    = (length == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue && (issued_d == length_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Last acceptance implies FIFO and read pipe are both empty.
                if (pop && (accepted_d == length_q)) begin
                    state_d = ST_FINISH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            length_q   <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            pipe_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            length_q   <= length_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            pipe_q     <= pipe_d;
        end
    end

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk_i      (clka),
        .rst_i      (reset),
        .push_vld_i (pipe_q[RD_LATENCY-1]),
        .push_dat_i (mem_rdata),
        .pop_i      (pop),
        .head_dat_o (out_data),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign mem_addr  = base_q + issued_q[ADDR_W-1:0];
    assign mem_read  = issue;
    assign out_valid = !fifo_empty;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);

endmodule

// File: tb/tb_dram_result_streamer.sv
// Drives two streamers in lockstep (read latency 1 and 3, four-entry FIFO) and
// checks each against a byte-level model of the DRAM region it should emit.
module tb_dram_result_streamer;

    localparam int DEPTH = 4;

    logic        clka = 1'b0;
    logic        reset;
    logic        start;
    logic        out_ready;
    logic [15:0] base_addr;
    logic [16:0] length;

    logic [15:0] mem_addr  [2];
    logic        mem_read  [2];
    logic [7:0]  out_data  [2];
    logic        out_valid [2];
    logic        busy      [2];
    logic        done      [2];

    logic [7:0]  rp0;
    logic [7:0]  rp1 [3];
    logic [7:0]  dram [0:65535];

    always #5 clka = ~clka;

    dram_result_streamer #(.RD_LATENCY(1), .FIFO_DEPTH(DEPTH)) dut0 (
        .clka(clka), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .mem_addr(mem_addr[0]), .mem_read(mem_read[0]), .mem_rdata(rp0),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .busy(busy[0]), .done(done[0])
    );

    dram_result_streamer #(.RD_LATENCY(3), .FIFO_DEPTH(DEPTH)) dut1 (
        .clka(clka), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .mem_addr(mem_addr[1]), .mem_read(mem_read[1]), .mem_rdata(rp1[2]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .busy(busy[1]), .done(done[1])
    );

    // DRAM model: data for the address presented at an edge appears LAT cycles later.
    always @(posedge clka) begin
        rp0    <= dram[mem_addr[0]];
        rp1[0] <= dram[mem_addr[1]];
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end

    int          cyc;
    int          start_cyc [2];
    int          first_vld [2];
    int          last_acc  [2];
    int          done_cyc  [2];
    int          done_n    [2];
    int          got_n     [2];
    int          rd_n      [2];
    int          valid_n   [2];
    int          stab_err  [2];
    int          ovf_err   [2];
    logic        busy_after [2];
    bit          stalled   [2];
    logic [7:0]  held      [2];
    logic [7:0]  got [2][0:63];
    logic [15:0] rda [2][0:63];

    int n_cmp;
    int n_fail;
    bit timed_out;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Observer: records what each DUT does, sampled on the falling edge.
    always @(negedge clka) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (start && !busy[k]) start_cyc[k] = cyc;
            if (cyc == start_cyc[k] + 1) busy_after[k] = busy[k];
            if (mem_read[k]) begin
                if (rd_n[k] < 64) rda[k][rd_n[k]] = mem_addr[k];
                rd_n[k]++;
            end
            if (out_valid[k]) begin
                valid_n[k]++;
                if (first_vld[k] < 0) first_vld[k] = cyc;
            end
            if (stalled[k] && (!out_valid[k] || out_data[k] !== held[k])) stab_err[k]++;
            stalled[k] = out_valid[k] && !out_ready;
            held[k]    = out_data[k];
            if (out_valid[k] && out_ready) begin
                if (got_n[k] < 64) got[k][got_n[k]] = out_data[k];
                got_n[k]++;
                last_acc[k] = cyc;
            end
            if (rd_n[k] - got_n[k] > DEPTH) ovf_err[k]++;
            if (done[k]) begin
                done_n[k]++;
                done_cyc[k] = cyc;
            end
        end
    end

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            start_cyc[k] = -100; first_vld[k] = -1; last_acc[k] = -1; done_cyc[k] = -1;
            done_n[k] = 0; got_n[k] = 0; rd_n[k] = 0; valid_n[k] = 0;
            stab_err[k] = 0; ovf_err[k] = 0; busy_after[k] = 1'bx; stalled[k] = 0;
        end
    endtask

    // Starts a transfer and runs until both DUTs are done (plus a few idle cycles),
    // or until DUT0 has accepted abort_at bytes when abort_at > 0.
    task automatic launch(input logic [15:0] b, input logic [16:0] n, input int pct,
                          input bit extra, input int abort_at);
        int post;
        clear_logs();
        base_addr = b; length = n; out_ready = (pct >= 100); start = 1'b1;
        @(posedge clka); #1;
        start = 1'b0; base_addr = 16'($urandom); length = 17'($urandom);
        timed_out = 1'b1;
        post = 0;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 99) < pct);
            start = extra && busy[0] && busy[1] && ($urandom_range(0, 3) == 0);
            if (start) begin
                base_addr = 16'($urandom); length = 17'($urandom_range(0, 64));
            end
            @(posedge clka); #1;
            start = 1'b0;
            if (abort_at > 0 && got_n[0] >= abort_at) begin
                timed_out = 1'b0;
                break;
            end
            if (done_n[0] > 0 && done_n[1] > 0) begin
                post++;
                if (post >= 6) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clka);
        @(negedge clka);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (mem_addr[k] !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr dut%0d: got %h expected 0000", k, mem_addr[k]); end
            n_cmp++; if (mem_read[k] !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read dut%0d: got %b expected 0", k, mem_read[k]); end
            n_cmp++; if (out_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid dut%0d: got %b expected 0", k, out_valid[k]); end
            n_cmp++; if (out_data[k] !== 8'h00) begin n_fail++; $display("FAIL reset_out_data dut%0d: got %h expected 00", k, out_data[k]); end
            n_cmp++; if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b expected 0", k, busy[k]); end
            n_cmp++; if (done[k] !== 1'b0) begin n_fail++; $display("FAIL reset_done dut%0d: got %b expected 0", k, done[k]); end
        end
        @(posedge clka); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) dram[i] = 8'(i);
        launch(16'h0000, 17'd16, 100, 1'b0, 0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (got_n[k] != 16) begin n_fail++; $display("FAIL basic_count dut%0d: got %0d expected 16", k, got_n[k]); end
            for (int i = 0; i < 16; i++) begin
                n_cmp++; if (got[k][i] !== 8'(i)) begin n_fail++; $display("FAIL basic_byte dut%0d[%0d]: got %h expected %h", k, i, got[k][i], 8'(i)); end
                n_cmp++; if (rda[k][i] !== 16'(i)) begin n_fail++; $display("FAIL basic_addr dut%0d[%0d]: got %h expected %h", k, i, rda[k][i], 16'(i)); end
            end
            // start cycle counts as 0: busy at +1, first byte RD_LATENCY+1 after that
            n_cmp++; if (first_vld[k] - start_cyc[k] != lat(k) + 2) begin n_fail++; $display("FAIL basic_latency dut%0d: got %0d expected %0d", k, first_vld[k] - start_cyc[k], lat(k) + 2); end
            n_cmp++; if (last_acc[k] - first_vld[k] != 15) begin n_fail++; $display("FAIL basic_rate dut%0d: got %0d cycles expected 15", k, last_acc[k] - first_vld[k]); end
            n_cmp++; if (done_n[k] != 1) begin n_fail++; $display("FAIL basic_done_count dut%0d: got %0d expected 1", k, done_n[k]); end
            n_cmp++; if (done_cyc[k] != last_acc[k] + 1) begin n_fail++; $display("FAIL basic_done_time dut%0d: got %0d expected %0d", k, done_cyc[k], last_acc[k] + 1); end
            n_cmp++; if (busy_after[k] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise dut%0d: got %b expected 1", k, busy_after[k]); end
            n_cmp++; if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end dut%0d: got %b expected 0", k, busy[k]); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] b = 16'h0010;
        for (int i = 0; i < 32; i++) dram[16'(b + i)] = 8'($urandom);
        launch(b, 17'd32, 50, 1'b0, 0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout: no done within budget"); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (got_n[k] != 32) begin n_fail++; $display("FAIL bp_count dut%0d: got %0d expected 32", k, got_n[k]); end
            for (int i = 0; i < 32; i++) begin
                n_cmp++; if (got[k][i] !== dram[16'(b + i)]) begin n_fail++; $display("FAIL bp_byte dut%0d[%0d]: got %h expected %h", k, i, got[k][i], dram[16'(b + i)]); end
            end
            n_cmp++; if (stab_err[k] != 0) begin n_fail++; $display("FAIL bp_stable dut%0d: %0d unstable stalled cycles, expected 0", k, stab_err[k]); end
            n_cmp++; if (ovf_err[k] != 0) begin n_fail++; $display("FAIL bp_overflow dut%0d: %0d cycles over %0d outstanding, expected 0", k, ovf_err[k], DEPTH); end
            n_cmp++; if (rd_n[k] != 32) begin n_fail++; $display("FAIL bp_reads dut%0d: got %0d expected 32", k, rd_n[k]); end
            n_cmp++; if (done_n[k] != 1) begin n_fail++; $display("FAIL bp_done_count dut%0d: got %0d expected 1", k, done_n[k]); end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] b = 16'hFFFE;
        for (int i = 0; i < 4; i++) dram[16'(b + i)] = 8'($urandom);
        launch(b, 17'd4, 100, 1'b0, 0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL wrap_timeout: no done within budget"); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (rd_n[k] != 4) begin n_fail++; $display("FAIL wrap_reads dut%0d: got %0d expected 4", k, rd_n[k]); end
            n_cmp++; if (got_n[k] != 4) begin n_fail++; $display("FAIL wrap_count dut%0d: got %0d expected 4", k, got_n[k]); end
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (rda[k][i] !== 16'(b + i)) begin n_fail++; $display("FAIL wrap_addr dut%0d[%0d]: got %h expected %h", k, i, rda[k][i], 16'(b + i)); end
                n_cmp++; if (got[k][i] !== dram[16'(b + i)]) begin n_fail++; $display("FAIL wrap_byte dut%0d[%0d]: got %h expected %h", k, i, got[k][i], dram[16'(b + i)]); end
            end
            n_cmp++; if (done_n[k] != 1) begin n_fail++; $display("FAIL wrap_done_count dut%0d: got %0d expected 1", k, done_n[k]); end
        end
    endtask

    task automatic test_zero_length();
        launch(16'h1234, 17'd0, 100, 1'b0, 0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL zero_timeout: no done within budget"); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (rd_n[k] != 0) begin n_fail++; $display("FAIL zero_reads dut%0d: got %0d expected 0", k, rd_n[k]); end
            n_cmp++; if (valid_n[k] != 0) begin n_fail++; $display("FAIL zero_valid dut%0d: got %0d valid cycles expected 0", k, valid_n[k]); end
            n_cmp++; if (done_n[k] != 1) begin n_fail++; $display("FAIL zero_done_count dut%0d: got %0d expected 1", k, done_n[k]); end
            n_cmp++; if (done_cyc[k] != start_cyc[k] + 1) begin n_fail++; $display("FAIL zero_done_time dut%0d: got %0d expected %0d", k, done_cyc[k], start_cyc[k] + 1); end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] b1 = 16'h0200;
        logic [15:0] b2 = 16'h0300;
        int done_snap [2];
        int valid_snap [2];
        int rd_snap [2];
        for (int i = 0; i < 20; i++) begin
            dram[16'(b1 + i)] = 8'($urandom);
            dram[16'(b2 + i)] = 8'($urandom);
        end
        launch(b1, 17'd20, 100, 1'b0, 5);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL rstmid_progress: DUT0 never accepted 5 bytes"); end
        reset = 1'b1;
        @(posedge clka);
        @(negedge clka);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (out_valid[k] !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid dut%0d: got %b expected 0", k, out_valid[k]); end
            n_cmp++; if (mem_read[k] !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_read dut%0d: got %b expected 0", k, mem_read[k]); end
            n_cmp++; if (mem_addr[k] !== 16'h0000) begin n_fail++; $display("FAIL rstmid_mem_addr dut%0d: got %h expected 0000", k, mem_addr[k]); end
            n_cmp++; if (out_data[k] !== 8'h00) begin n_fail++; $display("FAIL rstmid_out_data dut%0d: got %h expected 00", k, out_data[k]); end
            n_cmp++; if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy dut%0d: got %b expected 0", k, busy[k]); end
            n_cmp++; if (done[k] !== 1'b0) begin n_fail++; $display("FAIL rstmid_done dut%0d: got %b expected 0", k, done[k]); end
        end
        @(posedge clka); #1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            done_snap[k] = done_n[k]; valid_snap[k] = valid_n[k]; rd_snap[k] = rd_n[k];
        end
        repeat (8) @(posedge clka);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (done_n[k] != done_snap[k]) begin n_fail++; $display("FAIL rstmid_no_done dut%0d: got %0d done pulses expected 0", k, done_n[k] - done_snap[k]); end
            n_cmp++; if (valid_n[k] != valid_snap[k] || rd_n[k] != rd_snap[k]) begin n_fail++; $display("FAIL rstmid_quiet dut%0d: got %0d valid / %0d reads expected 0 / 0", k, valid_n[k] - valid_snap[k], rd_n[k] - rd_snap[k]); end
        end
        launch(b2, 17'd20, 100, 1'b0, 0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL rstmid_restart_timeout: no done within budget"); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (got_n[k] != 20) begin n_fail++; $display("FAIL rstmid_count dut%0d: got %0d expected 20", k, got_n[k]); end
            for (int i = 0; i < 20; i++) begin
                n_cmp++; if (got[k][i] !== dram[16'(b2 + i)]) begin n_fail++; $display("FAIL rstmid_byte dut%0d[%0d]: got %h expected %h", k, i, got[k][i], dram[16'(b2 + i)]); end
            end
            n_cmp++; if (done_n[k] != 1) begin n_fail++; $display("FAIL rstmid_done_count dut%0d: got %0d expected 1", k, done_n[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] b = 16'h0400;
        for (int i = 0; i < 24; i++) dram[16'(b + i)] = 8'($urandom);
        launch(b, 17'd24, 70, 1'b1, 0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL b2b_timeout: no done within budget"); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (got_n[k] != 24) begin n_fail++; $display("FAIL b2b_count dut%0d: got %0d expected 24", k, got_n[k]); end
            for (int i = 0; i < 24; i++) begin
                n_cmp++; if (got[k][i] !== dram[16'(b + i)]) begin n_fail++; $display("FAIL b2b_byte dut%0d[%0d]: got %h expected %h", k, i, got[k][i], dram[16'(b + i)]); end
            end
            n_cmp++; if (rd_n[k] != 24) begin n_fail++; $display("FAIL b2b_reads dut%0d: got %0d expected 24", k, rd_n[k]); end
            n_cmp++; if (done_n[k] != 1) begin n_fail++; $display("FAIL b2b_done_count dut%0d: got %0d expected 1", k, done_n[k]); end
            n_cmp++; if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end dut%0d: got %b expected 0", k, busy[k]); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        base_addr = '0; length = '0;
        n_cmp = 0; n_fail = 0; cyc = 0; timed_out = 1'b0;
        clear_logs();
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
